// File: rtl/avalon_st_pixel_source.sv
// Avalon-ST source output stage: buffers pixels in a 2-entry FIFO and frames
// them with startofpacket/endofpacket every FRAME_PIXELS beats.
// Latency: 1 cycle from input accept to src_valid_o (no bypass path).
// Backpressure: pix_ready_o drops when both entries are occupied, and is
//   combinational from registered count and clear_i only.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   clear_i                synchronous abort: flush FIFO, restart frame indexing
//   pix_valid_i/ready_o/data_i   internal pixel handshake
//   src_valid_o/ready_i/data_o/startofpacket_o/endofpacket_o   Avalon-ST source
//   frame_done_o           one-cycle pulse after the EOP beat is transferred
module avalon_st_pixel_source #(
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              pix_valid_i,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic              pix_ready_o,
  output logic              src_valid_o,
  output logic [DATA_W-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  input  logic              src_ready_i,
  output logic              frame_done_o
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_PIXELS - 1);

  // Each entry is {data, sop, eop}.
  logic [DATA_W+1:0] mem [2];
  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [15:0]       in_idx;
  logic              frame_done;

  logic              accept;
  logic              transfer;
  logic [DATA_W+1:0] head;
  logic              head_eop;
  logic              in_sop;
  logic              in_eop;

  assign head     = mem[rd_ptr];
  assign head_eop = head[0];
  assign in_sop   = (in_idx == 16'd0);
  assign in_eop   = (in_idx == LAST_IDX);

  always_comb begin
    pix_ready_o         = (count != 2'd2) && !clear_i;
    src_valid_o         = (count != 2'd0) && !clear_i;
    src_data_o          = '0;
    src_startofpacket_o = 1'b0;
    src_endofpacket_o   = 1'b0;
    // Outputs read zero while empty so an idle port never shows stale data.
    if (count != 2'd0) begin
      src_data_o          = head[DATA_W+1:2];
      src_startofpacket_o = head[1];
      src_endofpacket_o   = head[0];
    end
  end

  // Both handshakes already fold in !clear_i through the ready/valid terms.
  assign accept   = pix_valid_i && pix_ready_o;
  assign transfer = src_valid_o && src_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      in_idx     <= 16'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= transfer && head_eop;
      if (accept) begin
        wr_ptr <= ~wr_ptr;
        // Wrap only on the eop beat so frames always restart at index 0.
        in_idx <= in_eop ? 16'd0 : in_idx + 16'd1;
      end
      if (transfer) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, transfer})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (accept && !rst_i) begin
      mem[wr_ptr] <= {pix_data_i, in_sop, in_eop};
    end
  end

  assign frame_done_o = frame_done;

endmodule

// File: tb/tb_avalon_st_pixel_source.sv
module tb_avalon_st_pixel_source;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clr;
  // DUT A: FRAME_PIXELS = 16
  logic          pv, pr, sv, sop, eop, sr, fd;
  logic [DW-1:0] pd, sd;
  // DUT B: FRAME_PIXELS = 1
  logic          b_pv, b_pr, b_sv, b_sop, b_eop, b_sr, b_fd;
  logic [DW-1:0] b_pd, b_sd;
  logic          b_clr;

  int checks = 0;
  int passed = 0;

  avalon_st_pixel_source #(.DATA_W(DW), .FRAME_PIXELS(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .pix_valid_i(pv), .pix_data_i(pd), .pix_ready_o(pr),
    .src_valid_o(sv), .src_data_o(sd),
    .src_startofpacket_o(sop), .src_endofpacket_o(eop),
    .src_ready_i(sr), .frame_done_o(fd)
  );

  avalon_st_pixel_source #(.DATA_W(DW), .FRAME_PIXELS(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(b_clr),
    .pix_valid_i(b_pv), .pix_data_i(b_pd), .pix_ready_o(b_pr),
    .src_valid_o(b_sv), .src_data_o(b_sd),
    .src_startofpacket_o(b_sop), .src_endofpacket_o(b_eop),
    .src_ready_i(b_sr), .frame_done_o(b_fd)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pv = 1'b0; sr = 1'b0; clr = 1'b0; pd = '0;
    b_pv = 1'b0; b_sr = 1'b0; b_pd = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; b_clr = 1'b0;
    pv = 1'b1; pd = 8'h77; sr = 1'b0;
    b_pv = 1'b1; b_pd = 8'h99; b_sr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({sv, sop, eop, sd, fd} !== 12'h000) $display("FAIL reset_hold cyc%0d: got %h want 000", c, {sv, sop, eop, sd, fd});
      else passed++;
    end
    @(negedge clk);
    rst = 1'b0; pv = 1'b0; b_pv = 1'b0; #1;
    checks++;
    if ({pr, sv, fd} !== 3'b100) $display("FAIL reset_release: got %b want 100", {pr, sv, fd});
    else passed++;
    checks++;
    if ({b_pr, b_sv, b_fd} !== 3'b100) $display("FAIL reset_release_b: got %b want 100", {b_pr, b_sv, b_fd});
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({sv, sd} !== 9'h000) $display("FAIL reset_nothing_accepted: got %h want 000", {sv, sd});
    else passed++;
  endtask

  task automatic test_streaming();
    logic [10:0] exp;
    do_reset();
    sr = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      pv = (i < 16);
      pd = 8'(i);
      #1;
      if (i == 0) exp = 11'h000;
      else if (i <= 16) exp = {1'b1, (i == 1), (i == 16), 8'(i - 1)};
      else exp = 11'h000;
      checks++;
      if ({sv, sop, eop, sd} !== exp) $display("FAIL stream_beat %0d: got %h want %h", i, {sv, sop, eop, sd}, exp);
      else passed++;
      checks++;
      if (fd !== (i == 17)) $display("FAIL stream_frame_done cyc%0d: got %b want %b", i, fd, (i == 17));
      else passed++;
    end
    pv = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk); sr = 1'b0; pv = 1'b1; pd = 8'hA1; #1;
    checks++;
    if (pr !== 1'b1) $display("FAIL bp_ready0: got %b want 1", pr); else passed++;
    @(negedge clk); pd = 8'hA2; #1;
    checks++;
    if ({pr, sv, sop, sd} !== {3'b111, 8'hA1}) $display("FAIL bp_first: got %h want %h", {pr, sv, sop, sd}, {3'b111, 8'hA1});
    else passed++;
    @(negedge clk); pd = 8'hA3; #1;
    checks++;
    if ({pr, sv, sd} !== {2'b01, 8'hA1}) $display("FAIL bp_full: got %h want %h", {pr, sv, sd}, {2'b01, 8'hA1});
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({pr, sv, sd} !== {2'b01, 8'hA1}) $display("FAIL bp_hold: got %h want %h", {pr, sv, sd}, {2'b01, 8'hA1});
    else passed++;
    @(negedge clk); sr = 1'b1; #1;
    checks++;
    if ({pr, sv, sd} !== {2'b01, 8'hA1}) $display("FAIL bp_release: got %h want %h", {pr, sv, sd}, {2'b01, 8'hA1});
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({pr, sv, sd} !== {2'b11, 8'hA2}) $display("FAIL bp_second: got %h want %h", {pr, sv, sd}, {2'b11, 8'hA2});
    else passed++;
    @(negedge clk); pv = 1'b0; #1;
    checks++;
    if ({sv, sop, eop, sd} !== {3'b100, 8'hA3}) $display("FAIL bp_third: got %h want %h", {sv, sop, eop, sd}, {3'b100, 8'hA3});
    else passed++;
    @(negedge clk); #1;
    checks++;
    if (sv !== 1'b0) $display("FAIL bp_drained: got %b want 0", sv); else passed++;
  endtask

  task automatic test_random_stalls();
    logic [DW-1:0] din [48];
    logic [9:0]    exp;
    int ic, oc, nsop, neop, nfd, errs;
    ic = 0; oc = 0; nsop = 0; neop = 0; nfd = 0; errs = 0;
    do_reset();
    foreach (din[k]) din[k] = 8'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (fd === 1'b1) nfd++;
      if (oc == 48) break;
      pv = (ic < 48) && ($urandom_range(0, 3) != 0);
      pd = (ic < 48) ? din[ic] : 8'h00;
      sr = ($urandom_range(0, 2) != 0);
      #1;
      if (sv && sr) begin
        exp = {din[oc], (oc % 16 == 0), (oc % 16 == 15)};
        checks++;
        if ({sd, sop, eop} !== exp) $display("FAIL random_beat %0d: got %h want %h", oc, {sd, sop, eop}, exp);
        else passed++;
        if (sop) nsop++;
        if (eop) neop++;
        oc++;
      end
      if (pv && pr) ic++;
    end
    pv = 1'b0; sr = 1'b0;
    checks++;
    if (oc != 48) $display("FAIL random_count: got %0d beats want 48", oc); else passed++;
    checks++;
    if ({nsop, neop, nfd} !== {32'd3, 32'd3, 32'd3}) $display("FAIL random_framing: got sop=%0d eop=%0d done=%0d want 3 3 3", nsop, neop, nfd);
    else passed++;
  endtask

  task automatic test_mid_frame_clear();
    logic [10:0] exp;
    int neop, nfd;
    neop = 0; nfd = 0;
    do_reset();
    sr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); pv = 1'b1; pd = 8'(8'h10 + k); #1;
      if (sv && eop) neop++;
      if (fd) nfd++;
    end
    @(negedge clk); clr = 1'b1; pd = 8'hEE; #1;
    checks++;
    if ({sv, pr} !== 2'b00) $display("FAIL clear_outputs: got %b want 00", {sv, pr}); else passed++;
    @(negedge clk); clr = 1'b0; pv = 1'b0; #1;
    checks++;
    if ({sv, pr, sop, eop, sd} !== {4'b0100, 8'h00}) $display("FAIL clear_empty: got %h want %h", {sv, pr, sop, eop, sd}, {4'b0100, 8'h00});
    else passed++;
    if (fd) nfd++;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk); pv = (k < 16); pd = 8'(8'h20 + k); #1;
      if (k >= 1 && k <= 16) begin
        exp = {1'b1, (k == 1), (k == 16), 8'(8'h20 + k - 1)};
        checks++;
        if ({sv, sop, eop, sd} !== exp) $display("FAIL clear_refill beat %0d: got %h want %h", k, {sv, sop, eop, sd}, exp);
        else passed++;
      end
      if (sv && eop) neop++;
      if (fd) nfd++;
    end
    pv = 1'b0;
    checks++;
    if ({neop, nfd} !== {32'd1, 32'd1}) $display("FAIL clear_framing: got eop=%0d done=%0d want 1 1", neop, nfd);
    else passed++;
  endtask

  task automatic test_single_pixel_frame();
    logic [11:0] exp [5];
    exp[0] = 12'h000;
    exp[1] = {3'b111, 8'h55, 1'b0};
    exp[2] = {3'b111, 8'h66, 1'b1};
    exp[3] = {3'b000, 8'h00, 1'b1};
    exp[4] = 12'h000;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      b_sr = 1'b1;
      b_pv = (c < 2);
      b_pd = (c == 0) ? 8'h55 : 8'h66;
      #1;
      checks++;
      if ({b_sv, b_sop, b_eop, b_sd, b_fd} !== exp[c]) $display("FAIL fp1 cyc%0d: got %h want %h", c, {b_sv, b_sop, b_eop, b_sd, b_fd}, exp[c]);
      else passed++;
    end
    b_pv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_random_stalls();
    test_mid_frame_clear();
    test_single_pixel_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
